// File: rtl/bp_be_fwd_pipe_if.sv
// Dispatch / late-result / writeback bundle for bp_be_fwd_pipe.
// The master drives dispatch and result inputs; the pipe drives forwarding and writeback.
interface bp_be_fwd_pipe_if #(
  parameter int fwd_els_p = 4
);
  localparam int reg_addr_width_lp = 5;
  localparam int reg_data_width_lp = 64;

  logic                                               enter_v_i;
  logic                                               enter_rd_w_v_i;
  logic                                               enter_late_i;
  logic [reg_addr_width_lp-1:0]                       enter_rd_addr_i;
  logic [reg_data_width_lp-1:0]                       enter_data_i;
  logic                                               res_v_i;
  logic [reg_data_width_lp-1:0]                       res_data_i;
  logic                                               stall_i;
  logic                                               flush_i;

  logic                                               ready_o;
  logic                                               res_wait_o;
  logic [fwd_els_p-1:0]                               fwd_rd_v_o;
  logic [fwd_els_p-1:0][reg_addr_width_lp-1:0]        fwd_rd_addr_o;
  logic [fwd_els_p-1:0][reg_data_width_lp-1:0]        fwd_rd_o;
  logic                                               wb_v_o;
  logic [reg_addr_width_lp-1:0]                       wb_addr_o;
  logic [reg_data_width_lp-1:0]                       wb_data_o;
  logic                                               err_o;

  modport master (
    output enter_v_i, enter_rd_w_v_i, enter_late_i, enter_rd_addr_i, enter_data_i,
    output res_v_i, res_data_i, stall_i, flush_i,
    input  ready_o, res_wait_o, fwd_rd_v_o, fwd_rd_addr_o, fwd_rd_o,
    input  wb_v_o, wb_addr_o, wb_data_o, err_o
  );

  modport slave (
    input  enter_v_i, enter_rd_w_v_i, enter_late_i, enter_rd_addr_i, enter_data_i,
    input  res_v_i, res_data_i, stall_i, flush_i,
    output ready_o, res_wait_o, fwd_rd_v_o, fwd_rd_addr_o, fwd_rd_o,
    output wb_v_o, wb_addr_o, wb_data_o, err_o
  );
endinterface

// File: rtl/bp_be_fwd_pipe.sv
// Post-dispatch completion pipe: tracks in-flight rd writes, merges late results, feeds bypass and regfile.
// Optional protocol checker enabled by defining BP_BE_FWD_PIPE_CHECK_EN (sticky err_o).

// One pipe slot: advances from its source, or holds (with squash) while the pipe is frozen.
module bp_be_fwd_stage #(
  parameter int addr_w_p = 5,
  parameter int data_w_p = 64
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                hold,
  input  logic                kill,
  input  logic                src_v,
  input  logic                src_rd_w_v,
  input  logic                src_pend,
  input  logic [addr_w_p-1:0] src_addr,
  input  logic [data_w_p-1:0] src_data,
  input  logic                merge,
  input  logic [data_w_p-1:0] merge_data,
  output logic                v,
  output logic                rd_w_v,
  output logic                pend,
  output logic [addr_w_p-1:0] addr,
  output logic [data_w_p-1:0] data
);
  typedef struct packed {
    logic                v;
    logic                rd_w_v;
    logic                pend;
    logic [addr_w_p-1:0] addr;
    logic [data_w_p-1:0] data;
  } entry_t;

  entry_t r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r <= '0;
    end else if (hold) begin
      r.v <= r.v & ~kill;
      if (merge) begin
        r.pend <= 1'b0;
        r.data <= merge_data;
      end
    end else begin
      r <= '{v: src_v, rd_w_v: src_rd_w_v, pend: src_pend, addr: src_addr, data: src_data};
      if (merge) begin
        r.pend <= 1'b0;
        r.data <= merge_data;
      end
    end
  end

  assign v      = r.v;
  assign rd_w_v = r.rd_w_v;
  assign pend   = r.pend;
  assign addr   = r.addr;
  assign data   = r.data;
endmodule

module bp_be_fwd_pipe #(
  parameter int fwd_els_p      = 4,
  parameter int res_stage_p    = 1,
  parameter int commit_stage_p = 2
) (
  input logic             clk_i,
  input logic             reset_n_i,
  bp_be_fwd_pipe_if.slave io
);
  localparam int reg_addr_width_lp = 5;
  localparam int reg_data_width_lp = 64;
  localparam int last_lp           = fwd_els_p - 1;
  localparam bit res_squash_lp     = (res_stage_p < commit_stage_p);
  localparam bit wb_squash_lp      = (last_lp < commit_stage_p);

  logic [fwd_els_p-1:0]                        vld_pipe, rd_w_v, pend, kill, merge_en, fwd_v;
  logic [fwd_els_p-1:0]                        src_v, src_rd_w_v, src_pend;
  logic [fwd_els_p-1:0][reg_addr_width_lp-1:0] rd_addr, src_addr;
  logic [fwd_els_p-1:0][reg_data_width_lp-1:0] data, src_data;
  logic                                        res_pend, freeze, accept, merge;

  // A squashed res stage never blocks: its entry is dying this edge anyway.
  assign res_pend      = vld_pipe[res_stage_p] & pend[res_stage_p];
  assign io.res_wait_o = res_pend & ~io.res_v_i & ~(io.flush_i & res_squash_lp);
  assign freeze        = io.stall_i | io.res_wait_o;
  assign io.ready_o    = ~freeze & ~io.flush_i;
  assign accept        = io.enter_v_i & io.ready_o;
  assign merge         = io.res_v_i & res_pend;

  for (genvar s = 0; s < fwd_els_p; s++) begin : g_stage
    assign kill[s]     = io.flush_i & (s < commit_stage_p);
    // Late data lands where the res-stage entry sits after this edge.
    assign merge_en[s] = merge & (freeze ? (s == res_stage_p) : (s == res_stage_p + 1));

    if (s == 0) begin : g_src_enter
      assign src_v[s]      = accept;
      assign src_rd_w_v[s] = io.enter_rd_w_v_i;
      assign src_pend[s]   = io.enter_late_i;
      assign src_addr[s]   = io.enter_rd_addr_i;
      assign src_data[s]   = io.enter_data_i;
    end else begin : g_src_prev
      assign src_v[s]      = vld_pipe[s-1] & ~kill[s-1];
      assign src_rd_w_v[s] = rd_w_v[s-1];
      assign src_pend[s]   = pend[s-1];
      assign src_addr[s]   = rd_addr[s-1];
      assign src_data[s]   = data[s-1];
    end

    bp_be_fwd_stage #(
      .addr_w_p(reg_addr_width_lp),
      .data_w_p(reg_data_width_lp)
    ) u_stage (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .hold      (freeze),
      .kill      (kill[s]),
      .src_v     (src_v[s]),
      .src_rd_w_v(src_rd_w_v[s]),
      .src_pend  (src_pend[s]),
      .src_addr  (src_addr[s]),
      .src_data  (src_data[s]),
      .merge     (merge_en[s]),
      .merge_data(io.res_data_i),
      .v         (vld_pipe[s]),
      .rd_w_v    (rd_w_v[s]),
      .pend      (pend[s]),
      .addr      (rd_addr[s]),
      .data      (data[s])
    );

    assign fwd_v[s] = vld_pipe[s] & rd_w_v[s] & ~pend[s] & (rd_addr[s] != '0);
  end

  assign io.fwd_rd_v_o    = fwd_v;
  assign io.fwd_rd_addr_o = rd_addr;
  assign io.fwd_rd_o      = data;

  assign io.wb_v_o    = fwd_v[last_lp] & ~freeze & ~(io.flush_i & wb_squash_lp);
  assign io.wb_addr_o = rd_addr[last_lp];
  assign io.wb_data_o = data[last_lp];

`ifdef BP_BE_FWD_PIPE_CHECK_EN
  logic err_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_r <= 1'b0;
    end else if ((io.res_v_i & ~res_pend) | (io.enter_v_i & ~io.ready_o)) begin
      err_r <= 1'b1;
    end
  end

  assign io.err_o = err_r;
`else
  assign io.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_bp_be_fwd_pipe.sv
// Table-driven bench for bp_be_fwd_pipe (fwd_els_p=4, res_stage_p=1, commit_stage_p=2) with a writeback scoreboard.
module tb_bp_be_fwd_pipe;
  localparam int ELS = 4;
`ifdef BP_BE_FWD_PIPE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_be_fwd_pipe_if #(.fwd_els_p(ELS)) io ();

  bp_be_fwd_pipe #(.fwd_els_p(ELS), .res_stage_p(1), .commit_stage_p(2)) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .io       (io)
  );

  typedef struct {
    logic ev, rw, lt;
    logic [4:0] rd;
    logic [63:0] d;
    logic rv;
    logic [63:0] rdat;
    logic st, fl;
    logic e_rdy, e_wt;
    logic [3:0] e_fwd;
    logic e_wb;
    logic push;
    logic [63:0] sbd;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } wb_t;

  vec_t tbl[$];
  wb_t  sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic void add(input logic ev, rw, lt, input logic [4:0] rd, input logic [63:0] d,
                              input logic rv, input logic [63:0] rdat, input logic st, fl,
                              input logic rdy, wt, input logic [3:0] fwd, input logic wb,
                              input logic push, input logic [63:0] sbd);
    vec_t v;
    v = '{ev, rw, lt, rd, d, rv, rdat, st, fl, rdy, wt, fwd, wb, push, sbd};
    tbl.push_back(v);
  endfunction

  function automatic void idl(input logic rdy, wt, input logic [3:0] fwd, input logic wb);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, wt, fwd, wb, 0, 0);
  endfunction

  // Inputs change just after the edge; outputs are sampled mid-cycle at the falling edge.
  task automatic cyc(input logic ev, rw, lt, input logic [4:0] rd, input logic [63:0] d,
                     input logic rv, input logic [63:0] rdat, input logic st, fl);
    @(posedge clk);
    #1;
    io.enter_v_i = ev; io.enter_rd_w_v_i = rw; io.enter_late_i = lt;
    io.enter_rd_addr_i = rd; io.enter_data_i = d;
    io.res_v_i = rv; io.res_data_i = rdat; io.stall_i = st; io.flush_i = fl;
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && io.wb_v_o) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got addr %0h data %0h expected no write", io.wb_addr_o, io.wb_data_o);
      end else begin
        wb_t e;
        e = sbq.pop_front();
        chk("wb_addr", 64'(io.wb_addr_o), 64'(e.a));
        chk("wb_data", io.wb_data_o, e.d);
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 64'(io.ready_o), 1);
    chk({tag, "_wait"}, 64'(io.res_wait_o), 0);
    chk({tag, "_fwd_v"}, 64'(io.fwd_rd_v_o), 0);
    chk({tag, "_fwd_addr"}, 64'(io.fwd_rd_addr_o), 0);
    chk({tag, "_fwd_data0"}, io.fwd_rd_o[0], 0);
    chk({tag, "_fwd_data3"}, io.fwd_rd_o[3], 0);
    chk({tag, "_wb_v"}, 64'(io.wb_v_o), 0);
    chk({tag, "_err"}, 64'(io.err_o), 0);
  endtask

  initial begin
    io.enter_v_i = 0; io.enter_rd_w_v_i = 0; io.enter_late_i = 0;
    io.enter_rd_addr_i = 0; io.enter_data_i = 0;
    io.res_v_i = 0; io.res_data_i = 0; io.stall_i = 0; io.flush_i = 0;

    //   ev rw lt rd  d       rv rdat    st fl  rdy wt fwd      wb push sbd
    add(1, 1, 0, 5,  'hAA,   0, 0,      0, 0,  1, 0, 4'b0000, 0, 1, 'hAA);
    idl(1, 0, 4'b0001, 0); idl(1, 0, 4'b0010, 0); idl(1, 0, 4'b0100, 0); idl(1, 0, 4'b1000, 1);
    add(1, 1, 0, 0,  'h1,    0, 0,      0, 0,  1, 0, 4'b0000, 0, 0, 0);
    idl(1, 0, 4'b0000, 0); idl(1, 0, 4'b0000, 0); idl(1, 0, 4'b0000, 0); idl(1, 0, 4'b0000, 0);
    add(1, 1, 1, 7,  'h0,    0, 0,      0, 0,  1, 0, 4'b0000, 0, 1, 'h55);
    idl(1, 0, 4'b0000, 0);
    idl(0, 1, 4'b0000, 0); idl(0, 1, 4'b0000, 0); idl(0, 1, 4'b0000, 0);
    add(0, 0, 0, 0,  0,      1, 'h55,   0, 0,  1, 0, 4'b0000, 0, 0, 0);
    idl(1, 0, 4'b0100, 0); idl(1, 0, 4'b1000, 1);
    add(1, 1, 0, 3,  'h33,   0, 0,      0, 0,  1, 0, 4'b0000, 0, 1, 'h33);
    idl(1, 0, 4'b0001, 0); idl(1, 0, 4'b0010, 0); idl(1, 0, 4'b0100, 0);
    add(0, 0, 0, 0,  0,      0, 0,      1, 0,  0, 0, 4'b1000, 0, 0, 0);
    add(0, 0, 0, 0,  0,      0, 0,      1, 0,  0, 0, 4'b1000, 0, 0, 0);
    idl(1, 0, 4'b1000, 1); idl(1, 0, 4'b0000, 0);
    add(1, 1, 0, 10, 'hF0,   0, 0,      0, 0,  1, 0, 4'b0000, 0, 1, 'hF0);
    add(1, 1, 0, 11, 'h60,   0, 0,      0, 0,  1, 0, 4'b0001, 0, 0, 0);
    add(1, 1, 0, 12, 'h70,   0, 0,      0, 0,  1, 0, 4'b0011, 0, 0, 0);
    add(0, 0, 0, 0,  0,      0, 0,      0, 1,  0, 0, 4'b0111, 0, 0, 0);
    idl(1, 0, 4'b1000, 1); idl(1, 0, 4'b0000, 0);
    add(1, 1, 1, 4,  0,      0, 0,      0, 0,  1, 0, 4'b0000, 0, 1, 'h44);
    idl(1, 0, 4'b0000, 0);
    add(0, 0, 0, 0,  0,      1, 'h44,   1, 0,  0, 0, 4'b0000, 0, 0, 0);
    idl(1, 0, 4'b0010, 0); idl(1, 0, 4'b0100, 0); idl(1, 0, 4'b1000, 1); idl(1, 0, 4'b0000, 0);
    add(1, 1, 1, 6,  0,      0, 0,      0, 0,  1, 0, 4'b0000, 0, 0, 0);
    idl(1, 0, 4'b0000, 0);
    add(0, 0, 0, 0,  0,      1, 'h77,   0, 1,  0, 0, 4'b0000, 0, 0, 0);
    idl(1, 0, 4'b0000, 0);
    add(1, 1, 1, 8,  0,      0, 0,      0, 0,  1, 0, 4'b0000, 0, 0, 0);
    idl(1, 0, 4'b0000, 0); idl(0, 1, 4'b0000, 0);
    add(0, 0, 0, 0,  0,      0, 0,      0, 1,  0, 0, 4'b0000, 0, 0, 0);
    idl(1, 0, 4'b0000, 0); idl(1, 0, 4'b0000, 0); idl(1, 0, 4'b0000, 0);

    #2;
    chk_reset_state("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      cyc(v.ev, v.rw, v.lt, v.rd, v.d, v.rv, v.rdat, v.st, v.fl);
      if (v.push) sbq.push_back('{v.rd, v.sbd});
      chk($sformatf("v%0d_ready", i), 64'(io.ready_o), 64'(v.e_rdy));
      chk($sformatf("v%0d_wait", i), 64'(io.res_wait_o), 64'(v.e_wt));
      chk($sformatf("v%0d_fwd_v", i), 64'(io.fwd_rd_v_o), 64'(v.e_fwd));
      chk($sformatf("v%0d_wb_v", i), 64'(io.wb_v_o), 64'(v.e_wb));
      chk($sformatf("v%0d_err", i), 64'(io.err_o), 0);
    end

    // Forwarded addr/data follow the entry through the stages.
    cyc(1, 1, 0, 5'd21, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0);
    sbq.push_back('{5'd21, 64'hDEAD_BEEF_0123_4567});
    idle_cyc();
    chk("h0_addr0", 64'(io.fwd_rd_addr_o[0]), 21);
    chk("h0_data0", io.fwd_rd_o[0], 64'hDEAD_BEEF_0123_4567);
    idle_cyc(); idle_cyc();
    chk("h0_addr2", 64'(io.fwd_rd_addr_o[2]), 21);
    chk("h0_data2", io.fwd_rd_o[2], 64'hDEAD_BEEF_0123_4567);
    idle_cyc(); idle_cyc(); idle_cyc();

    // Dispatch while stalled is dropped (and flagged when checking is built in).
    cyc(1, 1, 0, 5'd9, 64'h99, 0, 0, 1, 0);
    chk("h1_ready", 64'(io.ready_o), 0);
    idle_cyc();
    chk("h1_fwd_v", 64'(io.fwd_rd_v_o), 0);
    chk("h1_err", 64'(io.err_o), 64'(CHK));
    idle_cyc(); idle_cyc();
    chk("h1_fwd_v_later", 64'(io.fwd_rd_v_o), 0);

    rst_n = 1'b0;
    #1;
    chk_reset_state("h1_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Stray late result on an empty pipe; err is sticky until async reset.
    cyc(0, 0, 0, 0, 0, 1, 64'h5A, 0, 0);
    chk("h2_wait", 64'(io.res_wait_o), 0);
    idle_cyc();
    chk("h2_err", 64'(io.err_o), 64'(CHK));
    chk("h2_fwd_v", 64'(io.fwd_rd_v_o), 0);
    idle_cyc(); idle_cyc();
    chk("h2_err_sticky", 64'(io.err_o), 64'(CHK));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("h2_err_async_clr", 64'(io.err_o), 0);
    chk_reset_state("h2_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cyc(); idle_cyc();

    chk("sb_drained", 64'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
